// File: rtl/adder_issue_arb.sv
// Two-requester round-robin issue stage for an external adder, with credit-based
// flow control and an in-order result buffer carrying requester id and tag.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef CTRL_ADD
`define CTRL_ADD  2'd0
`endif
`ifndef CTRL_SUB
`define CTRL_SUB  2'd1
`endif
`ifndef CTRL_ADDI
`define CTRL_ADDI 2'd2
`endif

module adder_issue_arb #(
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int TAG_W      = 4,
  parameter int ADD_LAT    = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0]            req0_add_type,
  input  logic [1:0]            req1_add_type,
  input  logic [DATA_WIDTH-1:0] req0_src1,
  input  logic [DATA_WIDTH-1:0] req0_src2,
  input  logic [DATA_WIDTH-1:0] req1_src1,
  input  logic [DATA_WIDTH-1:0] req1_src2,
  input  logic [20:0]           req0_imm,
  input  logic [20:0]           req1_imm,
  input  logic [TAG_W-1:0]      req0_tag,
  input  logic [TAG_W-1:0]      req1_tag,
  output logic                  uop_valid_out,
  output logic [1:0]            add_type_out,
  output logic [DATA_WIDTH-1:0] src1_out,
  output logic [DATA_WIDTH-1:0] src2_out,
  output logic [20:0]           imm_out,
  input  logic [DATA_WIDTH-1:0] add_value,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_id,
  output logic [TAG_W-1:0]      rsp_tag,
  output logic [DATA_WIDTH-1:0] rsp_data
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int USE_W = $clog2(FIFO_DEPTH + ADD_LAT + 2) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);

  logic                  r_last;
  logic                  r_uop_valid;
  logic [1:0]            r_add_type;
  logic [DATA_WIDTH-1:0] r_src1;
  logic [DATA_WIDTH-1:0] r_src2;
  logic [20:0]           r_imm;
  logic                  r_iss_id;
  logic [TAG_W-1:0]      r_iss_tag;

  logic                  r_trk_valid [ADD_LAT];
  logic                  r_trk_id    [ADD_LAT];
  logic [TAG_W-1:0]      r_trk_tag   [ADD_LAT];

  logic [DATA_WIDTH-1:0] r_mem_data [FIFO_DEPTH];
  logic                  r_mem_id   [FIFO_DEPTH];
  logic [TAG_W-1:0]      r_mem_tag  [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;

  logic [USE_W-1:0]      w_used;
  logic                  w_can_grant;
  logic                  w_acc;
  logic                  w_sel;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_chain_valid [ADD_LAT+1];
  logic                  w_chain_id    [ADD_LAT+1];
  logic [TAG_W-1:0]      w_chain_tag   [ADD_LAT+1];

  function automatic logic [PTR_W-1:0] f_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // Occupied credits: buffered results plus everything between issue and push.
  always_comb begin
    w_used = USE_W'(r_count) + USE_W'(r_uop_valid);
    for (int k = 0; k < ADD_LAT; k++) begin
      w_used = w_used + USE_W'(r_trk_valid[k]);
    end
  end

  assign w_can_grant  = reset & ~flush & (w_used < USE_W'(FIFO_DEPTH));
  assign req_ready[0] = w_can_grant & req_valid[0] & (~req_valid[1] | r_last);
  assign req_ready[1] = w_can_grant & req_valid[1] & (~req_valid[0] | ~r_last);
  assign w_acc        = |(req_valid & req_ready);
  assign w_sel        = req_ready[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last      <= 1'b1;
      r_uop_valid <= 1'b0;
      r_add_type  <= '0;
      r_src1      <= '0;
      r_src2      <= '0;
      r_imm       <= '0;
      r_iss_id    <= 1'b0;
      r_iss_tag   <= '0;
    end else begin
      r_uop_valid <= w_acc;
      if (w_acc) begin
        r_last     <= w_sel;
        r_iss_id   <= w_sel;
        r_add_type <= w_sel ? req1_add_type : req0_add_type;
        r_src1     <= w_sel ? req1_src1 : req0_src1;
        r_src2     <= w_sel ? req1_src2 : req0_src2;
        r_imm      <= w_sel ? req1_imm : req0_imm;
        r_iss_tag  <= w_sel ? req1_tag : req0_tag;
      end
    end
  end

  assign uop_valid_out = r_uop_valid;
  assign add_type_out  = r_add_type;
  assign src1_out      = r_src1;
  assign src2_out      = r_src2;
  assign imm_out       = r_imm;

  // Chain index 0 is the issue register; stage gi follows chain entry gi.
  assign w_chain_valid[0] = r_uop_valid;
  assign w_chain_id[0]    = r_iss_id;
  assign w_chain_tag[0]   = r_iss_tag;

  generate
    for (genvar gi = 0; gi < ADD_LAT; gi++) begin : g_trk
      assign w_chain_valid[gi+1] = r_trk_valid[gi];
      assign w_chain_id[gi+1]    = r_trk_id[gi];
      assign w_chain_tag[gi+1]   = r_trk_tag[gi];

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_trk_valid[gi] <= 1'b0;
          r_trk_id[gi]    <= 1'b0;
          r_trk_tag[gi]   <= '0;
        end else begin
          r_trk_valid[gi] <= w_chain_valid[gi] & ~flush;
          r_trk_id[gi]    <= w_chain_id[gi];
          r_trk_tag[gi]   <= w_chain_tag[gi];
        end
      end
    end
  endgenerate

  assign w_push = w_chain_valid[ADD_LAT] & ~flush;
  assign w_pop  = (r_count != '0) & rsp_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int k = 0; k < FIFO_DEPTH; k++) begin
        r_mem_data[k] <= '0;
        r_mem_id[k]   <= 1'b0;
        r_mem_tag[k]  <= '0;
      end
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem_data[r_wr_ptr] <= add_value;
        r_mem_id[r_wr_ptr]   <= w_chain_id[ADD_LAT];
        r_mem_tag[r_wr_ptr]  <= w_chain_tag[ADD_LAT];
        r_wr_ptr             <= f_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= f_inc(r_rd_ptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign rsp_valid = (r_count != '0);
  assign rsp_id    = r_mem_id[r_rd_ptr];
  assign rsp_tag   = r_mem_tag[r_rd_ptr];
  assign rsp_data  = r_mem_data[r_rd_ptr];

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
    !(w_push && (r_count == DEPTH_C)));

endmodule

// File: tb/tb_adder_issue_arb.sv
// Directed bench for adder_issue_arb: a queue-driven requester driver, a
// one-cycle adder model, and a scoreboard monitor on the response port.
`ifndef CTRL_ADD
`define CTRL_ADD  2'd0
`endif
`ifndef CTRL_SUB
`define CTRL_SUB  2'd1
`endif
`ifndef CTRL_ADDI
`define CTRL_ADDI 2'd2
`endif

module tb_adder_issue_arb;
  logic        clk = 1'b0;
  logic        reset, flush, rsp_ready;
  logic [1:0]  req_valid, req_ready;
  logic [1:0]  req0_add_type, req1_add_type;
  logic [31:0] req0_src1, req0_src2, req1_src1, req1_src2;
  logic [20:0] req0_imm, req1_imm;
  logic [3:0]  req0_tag, req1_tag;
  logic        uop_valid_out;
  logic [1:0]  add_type_out;
  logic [31:0] src1_out, src2_out;
  logic [20:0] imm_out;
  logic [31:0] add_value;
  logic        rsp_valid, rsp_id;
  logic [3:0]  rsp_tag;
  logic [31:0] rsp_data;

  adder_issue_arb dut (
    .clk(clk), .reset(reset), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_add_type(req0_add_type), .req1_add_type(req1_add_type),
    .req0_src1(req0_src1), .req0_src2(req0_src2),
    .req1_src1(req1_src1), .req1_src2(req1_src2),
    .req0_imm(req0_imm), .req1_imm(req1_imm),
    .req0_tag(req0_tag), .req1_tag(req1_tag),
    .uop_valid_out(uop_valid_out), .add_type_out(add_type_out),
    .src1_out(src1_out), .src2_out(src2_out), .imm_out(imm_out),
    .add_value(add_value),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_tag(rsp_tag), .rsp_data(rsp_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  typ;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [20:0] imm;
    logic [3:0]  tag;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic        id;
    logic [3:0]  tag;
    logic [31:0] data;
  } rsp_t;

  vec_t q0[$];
  vec_t q1[$];
  rsp_t sb[$];
  int   grant_log[$];
  int   grant_cyc[$];
  int   n_acc = 0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  function automatic vec_t mk(input logic [1:0] t, input logic [31:0] a, input logic [31:0] b,
                              input logic [20:0] im, input logic [3:0] tg, input logic [31:0] ex);
    vec_t v;
    v.typ = t; v.s1 = a; v.s2 = b; v.imm = im; v.tag = tg; v.exp = ex;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic to_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_acc(input string name, input int target, input int limit);
    int k;
    for (k = 0; k < limit && n_acc < target; k++) step(1);
    if (n_acc < target) begin
      total++; bad++;
      $display("FAIL %s timeout accepts=%0d required=%0d", name, n_acc, target);
    end
  endtask

  task automatic wait_drain(input string name, input int limit);
    int k;
    for (k = 0; k < limit && (sb.size() != 0 || q0.size() != 0 || q1.size() != 0); k++) step(1);
    total++;
    if (sb.size() != 0 || q0.size() != 0 || q1.size() != 0) begin
      bad++;
      $display("FAIL %s timeout pending_rsp=%0d pending_req=%0d required=0", name, sb.size(),
               q0.size() + q1.size());
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Requester driver: drive queue fronts after the edge, detect handshakes before the next one.
  initial begin
    rsp_t e;
    req_valid = '0;
    req0_add_type = '0; req1_add_type = '0;
    req0_src1 = '0; req0_src2 = '0; req1_src1 = '0; req1_src2 = '0;
    req0_imm = '0; req1_imm = '0; req0_tag = '0; req1_tag = '0;
    forever begin
      @(posedge clk);
      #1;
      req_valid[0] = (q0.size() > 0);
      if (q0.size() > 0) begin
        req0_add_type = q0[0].typ; req0_src1 = q0[0].s1; req0_src2 = q0[0].s2;
        req0_imm = q0[0].imm; req0_tag = q0[0].tag;
      end
      req_valid[1] = (q1.size() > 0);
      if (q1.size() > 0) begin
        req1_add_type = q1[0].typ; req1_src1 = q1[0].s1; req1_src2 = q1[0].s2;
        req1_imm = q1[0].imm; req1_tag = q1[0].tag;
      end
      @(negedge clk);
      if (reset && req_valid[0] && req_ready[0] && q0.size() > 0) begin
        e.id = 1'b0; e.tag = q0[0].tag; e.data = q0[0].exp;
        sb.push_back(e);
        void'(q0.pop_front());
        grant_log.push_back(0); grant_cyc.push_back(cyc); n_acc++;
        $display("acc id=0 tag=%0d cyc=%0d", e.tag, cyc);
      end else if (reset && req_valid[1] && req_ready[1] && q1.size() > 0) begin
        e.id = 1'b1; e.tag = q1[0].tag; e.data = q1[0].exp;
        sb.push_back(e);
        void'(q1.pop_front());
        grant_log.push_back(1); grant_cyc.push_back(cyc); n_acc++;
        $display("acc id=1 tag=%0d cyc=%0d", e.tag, cyc);
      end
    end
  end

  // Adder model: result for an issue seen in cycle N is presented throughout cycle N+1.
  initial begin
    logic        v;
    logic [1:0]  t;
    logic [31:0] a, b;
    logic [20:0] im;
    add_value = '0;
    forever begin
      @(negedge clk);
      v = uop_valid_out; t = add_type_out; a = src1_out; b = src2_out; im = imm_out;
      @(posedge clk);
      #1;
      if (v) begin
        case (t)
          `CTRL_ADD:  add_value = a + b;
          `CTRL_SUB:  add_value = a - b;
          `CTRL_ADDI: add_value = a + {11'd0, im};
          default:    add_value = 32'h0;
        endcase
      end
    end
  end

  // Response monitor / scoreboard.
  initial forever begin
    rsp_t e;
    @(negedge clk);
    if (reset && rsp_valid && rsp_ready) begin
      $display("rsp id=%0d tag=%0d data=0x%0h cyc=%0d", rsp_id, rsp_tag, rsp_data, cyc);
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_rsp actual_tag=%0d required=none", rsp_tag);
      end else begin
        e = sb.pop_front();
        check("rsp_id", rsp_id, e.id);
        check("rsp_tag", rsp_tag, e.tag);
        check("rsp_data", rsp_data, e.data);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, nb;
    reset = 1'b0; flush = 1'b0; rsp_ready = 1'b1;

    // Held in reset with a request pending: nothing may be granted or presented.
    q0.push_back(mk(`CTRL_ADD, 32'd1, 32'd1, 21'd0, 4'd0, 32'd2));
    step(2);
    check("rst_req_ready", req_ready, 2'b00);
    check("rst_uop_valid", uop_valid_out, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_rsp_tag", rsp_tag, 4'd0);
    check("rst_src1", src1_out, 32'd0);
    q0.delete();
    to_pos(); to_pos();
    reset = 1'b1;
    step(1);

    // Continuous contention right after reset: 0,1,0,1 back to back.
    grant_log.delete(); grant_cyc.delete();
    base = n_acc;
    q0.push_back(mk(`CTRL_ADD, 32'd1, 32'd2, 21'd0, 4'd1, 32'd3));
    q0.push_back(mk(`CTRL_ADD, 32'd100, 32'd23, 21'd0, 4'd2, 32'd123));
    q1.push_back(mk(`CTRL_ADD, 32'd40, 32'd2, 21'd0, 4'd9, 32'd42));
    q1.push_back(mk(`CTRL_SUB, 32'd50, 32'd9, 21'd0, 4'd10, 32'd41));
    wait_acc("rr_accepts", base + 4, 20);
    check("rr_count", grant_log.size(), 4);
    if (grant_log.size() >= 4) begin
      check("rr_grant0", grant_log[0], 0);
      check("rr_grant1", grant_log[1], 1);
      check("rr_grant2", grant_log[2], 0);
      check("rr_grant3", grant_log[3], 1);
      check("b2b_span", grant_cyc[3] - grant_cyc[0], 3);
    end
    wait_drain("rr_drain", 30);

    // Single ADD: issue one cycle after accept, response three cycles after.
    base = n_acc;
    q0.push_back(mk(`CTRL_ADD, 32'd5, 32'd7, 21'd0, 4'd3, 32'd12));
    wait_acc("single_accept", base + 1, 20);
    step(1);
    check("uop_valid_n1", uop_valid_out, 1'b1);
    check("uop_src1", src1_out, 32'd5);
    check("uop_src2", src2_out, 32'd7);
    check("uop_type", add_type_out, `CTRL_ADD);
    step(1);
    check("uop_valid_n2", uop_valid_out, 1'b0);
    check("payload_hold", src1_out, 32'd5);
    check("rsp_not_early", rsp_valid, 1'b0);
    step(1);
    check("rsp_valid_n3", rsp_valid, 1'b1);
    wait_drain("single_drain", 20);

    // SUB, ADDI with full 21-bit immediate, and SUB wrap-around.
    q1.push_back(mk(`CTRL_SUB, 32'd10, 32'd3, 21'd0, 4'd5, 32'd7));
    q0.push_back(mk(`CTRL_ADDI, 32'd1, 32'hDEADBEEF, 21'h1FFFFF, 4'd6, 32'h00200000));
    q1.push_back(mk(`CTRL_SUB, 32'd3, 32'd10, 21'd0, 4'd7, 32'hFFFFFFF9));
    wait_drain("ops_drain", 30);

    // Backpressure: exactly FIFO_DEPTH accepts, then resume one cycle after the first pop.
    to_pos();
    rsp_ready = 1'b0;
    step(1);
    base = n_acc;
    for (int i = 1; i <= 6; i++)
      q0.push_back(mk(`CTRL_ADD, 32'(16 * i), 32'(i), 21'd0, 4'(i), 32'(17 * i)));
    step(10);
    check("stall_accepts", n_acc - base, 4);
    check("stall_ready", req_ready, 2'b00);
    check("stall_rsp_valid", rsp_valid, 1'b1);
    check("stall_data_a", rsp_data, 32'd17);
    step(1);
    check("stall_data_b", rsp_data, 32'd17);
    check("stall_tag", rsp_tag, 4'd1);
    to_pos();
    rsp_ready = 1'b1;
    nb = n_acc;
    step(1);
    check("no_acc_at_pop", n_acc - nb, 0);
    step(1);
    check("acc_after_pop", n_acc - nb, 1);
    wait_drain("stall_drain", 40);

    // Flush with two buffered and two in flight.
    to_pos();
    rsp_ready = 1'b0;
    step(1);
    base = n_acc;
    for (int i = 0; i < 4; i++)
      q0.push_back(mk(`CTRL_ADD, 32'(256 + i), 32'd0, 21'd0, 4'(8 + i), 32'(256 + i)));
    wait_acc("flush_fill", base + 4, 20);
    check("pre_flush_valid", rsp_valid, 1'b1);
    to_pos();
    flush = 1'b1;
    sb.delete();
    to_pos();
    flush = 1'b0;
    step(1);
    check("flush_rsp_valid", rsp_valid, 1'b0);
    check("flush_uop_valid", uop_valid_out, 1'b0);
    base = n_acc;
    for (int i = 1; i <= 5; i++)
      q0.push_back(mk(`CTRL_ADD, 32'(i), 32'(i), 21'd0, 4'(i), 32'(2 * i)));
    step(10);
    check("flush_credits", n_acc - base, 4);
    check("flush_fresh_tag", rsp_tag, 4'd1);
    check("flush_fresh_data", rsp_data, 32'd2);
    to_pos();
    rsp_ready = 1'b1;
    wait_drain("flush_drain", 40);

    // Asynchronous reset mid-burst.
    step(1);
    for (int i = 0; i < 4; i++) begin
      q0.push_back(mk(`CTRL_ADD, 32'(i), 32'd1, 21'd0, 4'(i), 32'(i + 1)));
      q1.push_back(mk(`CTRL_ADD, 32'(i), 32'd2, 21'd0, 4'(i + 4), 32'(i + 2)));
    end
    step(3);
    to_pos();
    #2;
    reset = 1'b0;
    #1;
    check("arst_req_ready", req_ready, 2'b00);
    check("arst_uop_valid", uop_valid_out, 1'b0);
    check("arst_type", add_type_out, 2'd0);
    check("arst_src1", src1_out, 32'd0);
    check("arst_src2", src2_out, 32'd0);
    check("arst_imm", imm_out, 21'd0);
    check("arst_rsp_valid", rsp_valid, 1'b0);
    check("arst_rsp_id", rsp_id, 1'b0);
    check("arst_rsp_tag", rsp_tag, 4'd0);
    check("arst_rsp_data", rsp_data, 32'd0);
    q0.delete(); q1.delete(); sb.delete();
    step(2);
    to_pos();
    reset = 1'b1;
    step(6);
    check("post_reset_no_rsp", rsp_valid, 1'b0);
    grant_log.delete();
    base = n_acc;
    q0.push_back(mk(`CTRL_ADD, 32'd2, 32'd2, 21'd0, 4'd2, 32'd4));
    q1.push_back(mk(`CTRL_ADD, 32'd3, 32'd3, 21'd0, 4'd3, 32'd6));
    wait_acc("post_reset_accepts", base + 2, 20);
    check("post_reset_count", grant_log.size(), 2);
    if (grant_log.size() >= 2) begin
      check("post_reset_first", grant_log[0], 0);
      check("post_reset_second", grant_log[1], 1);
    end
    wait_drain("post_reset_drain", 30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
